// File: rtl/sram_bus_responder_pkg.sv
// rtl/sram_bus_responder_pkg.sv - shared state encodings and memory geometry for the SRAM bus responder
package sram_bus_responder_pkg;

  localparam int MEM_DEPTH = 512;
  localparam int MEM_IDX_W = 9;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ_WAIT  = 3'd1,
    READ_BEAT  = 3'd2,
    READ_END   = 3'd3,
    WRITE      = 3'd4,
    WRITE_BUSY = 3'd5,
    ERROR      = 3'd6
  } state_t;

endpackage

// File: rtl/sram_bus_mem.sv
// rtl/sram_bus_mem.sv - 512x32 single-port memory with byte write enables and registered read
module sram_bus_mem
  import sram_bus_responder_pkg::*;
(
  input  logic                 clock,
  input  logic [MEM_IDX_W-1:0] addr,
  input  logic [3:0]           we,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [MEM_DEPTH];

  // Byte-lane writes and a read-first registered read of the same word.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_bus_responder.sv
// rtl/sram_bus_responder.sv - bus slave in front of a 512-word SRAM with burst reads and writes
module sram_bus_responder
  import sram_bus_responder_pkg::*;
#(
  parameter logic [31:0] baseAddress     = 32'h5000_0000,
  parameter int          writeWaitStates = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic [7:0]  burstSizeIn,
  input  logic        readNotWriteIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busErrorOut,
  output logic        busyOut
);

  localparam logic [1:0] WAIT_N = 2'(writeWaitStates);

  state_t               state, next_state;
  logic [MEM_IDX_W-1:0] ptr, next_ptr;
  logic [8:0]           beat_cnt, next_beat_cnt;
  logic [1:0]           wait_cnt, next_wait_cnt;
  logic [7:0]           burst, next_burst;
  logic [3:0]           be, next_be;

  logic [MEM_IDX_W-1:0] mem_addr;
  logic [3:0]           mem_we;
  logic [31:0]          mem_rdata;

  logic [MEM_IDX_W-1:0] begin_idx;
  logic [MEM_IDX_W:0]   end_idx;
  logic                 selected;
  logic                 begin_bad;
  logic                 beat_ok;

  assign begin_idx = addressDataIn[10:2];
  assign selected  = beginTransactionIn && (addressDataIn[31:11] == baseAddress[31:11]);
  // Bit 9 of the last-word index flags a burst running past the top of memory.
  assign end_idx   = {1'b0, begin_idx} + {2'b00, burstSizeIn};
  assign begin_bad = (addressDataIn[1:0] != 2'b00) || end_idx[MEM_IDX_W];
  // beat_cnt holds beats already accepted; one more is allowed while it is <= burst.
  assign beat_ok   = beat_cnt <= {1'b0, burst};

  sram_bus_mem u_mem (
    .clock (clock),
    .addr  (mem_addr),
    .we    (mem_we),
    .wdata (addressDataIn),
    .rdata (mem_rdata)
  );

  // Next-state, datapath updates and memory port control.
  always_comb begin
    next_state    = state;
    next_ptr      = ptr;
    next_beat_cnt = beat_cnt;
    next_wait_cnt = wait_cnt;
    next_burst    = burst;
    next_be       = be;
    mem_addr      = ptr;
    mem_we        = 4'b0000;
    case (state)
      IDLE: begin
        // Read the first word straight from the bus address so it is ready in READ_WAIT.
        mem_addr = begin_idx;
        if (selected) begin
          next_burst    = burstSizeIn;
          next_be       = byteEnablesIn;
          next_beat_cnt = '0;
          next_wait_cnt = '0;
          if (begin_bad) begin
            next_state = ERROR;
          end else if (readNotWriteIn) begin
            next_state = READ_WAIT;
            next_ptr   = begin_idx + 1'b1;
          end else begin
            next_state = WRITE;
            next_ptr   = begin_idx;
          end
        end
      end
      READ_WAIT: begin
        next_ptr   = ptr + 1'b1;
        next_state = endTransactionIn ? IDLE : READ_BEAT;
      end
      READ_BEAT: begin
        next_ptr = ptr + 1'b1;
        if (endTransactionIn) begin
          next_state = IDLE;
        end else if (beat_cnt == {1'b0, burst}) begin
          next_state = READ_END;
        end else begin
          next_beat_cnt = beat_cnt + 1'b1;
        end
      end
      READ_END: next_state = IDLE;
      WRITE: begin
        if (dataValidIn) begin
          if (!beat_ok) begin
            next_state = ERROR;
          end else begin
            mem_we        = be;
            next_ptr      = ptr + 1'b1;
            next_beat_cnt = beat_cnt + 1'b1;
            if (endTransactionIn) begin
              next_state = IDLE;
            end else if (writeWaitStates > 0) begin
              next_state    = WRITE_BUSY;
              next_wait_cnt = 2'd1;
            end
          end
        end else if (endTransactionIn) begin
          next_state = IDLE;
        end
      end
      WRITE_BUSY: begin
        if (endTransactionIn) begin
          next_state = IDLE;
        end else if (wait_cnt == WAIT_N) begin
          next_state = WRITE;
        end else begin
          next_wait_cnt = wait_cnt + 1'b1;
        end
      end
      ERROR:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, datapath and output registers; outputs follow the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      ptr               <= '0;
      beat_cnt          <= '0;
      wait_cnt          <= '0;
      burst             <= '0;
      be                <= '0;
      addressDataOut    <= '0;
      dataValidOut      <= 1'b0;
      endTransactionOut <= 1'b0;
      busErrorOut       <= 1'b0;
      busyOut           <= 1'b0;
    end else begin
      state             <= next_state;
      ptr               <= next_ptr;
      beat_cnt          <= next_beat_cnt;
      wait_cnt          <= next_wait_cnt;
      burst             <= next_burst;
      be                <= next_be;
      addressDataOut    <= (next_state == READ_BEAT) ? mem_rdata : 32'h0;
      dataValidOut      <= (next_state == READ_BEAT);
      endTransactionOut <= (next_state == READ_END) || (next_state == ERROR);
      busErrorOut       <= (next_state == ERROR);
      busyOut           <= (next_state == WRITE_BUSY);
    end
  end

endmodule

// File: tb/tb_sram_bus_responder.sv
// tb/tb_sram_bus_responder.sv - directed self-checking bench for sram_bus_responder
module tb_sram_bus_responder;

  localparam logic [31:0] BASE = 32'h5000_0000;
  localparam logic [31:0] WA = 32'hA1A2_A3A4;
  localparam logic [31:0] WB = 32'hB1B2_B3B4;
  localparam logic [31:0] WC = 32'hC1C2_C3C4;
  localparam logic [31:0] WD = 32'hD1D2_D3D4;
  localparam logic [31:0] WC_BE = 32'hC1C2_CCDD;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        beginTransactionIn = 1'b0;
  logic [31:0] addressDataIn = '0;
  logic [3:0]  byteEnablesIn = '0;
  logic [7:0]  burstSizeIn = '0;
  logic        readNotWriteIn = 1'b0;
  logic        dataValidIn = 1'b0;
  logic        endTransactionIn = 1'b0;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busErrorOut;
  logic        busyOut;

  int checks = 0;
  int failures = 0;

  logic [31:0] wbuf [8];
  logic [31:0] rd_buf [8];
  logic [7:0]  rd_vmask;
  logic        rd_pre_valid;
  logic        rd_end;
  logic        rd_end_valid;
  logic        rd_idle_any;

  always #5 clock = ~clock;

  sram_bus_responder #(.baseAddress(BASE), .writeWaitStates(2)) dut (
    .clock             (clock),
    .reset             (reset),
    .beginTransactionIn(beginTransactionIn),
    .addressDataIn     (addressDataIn),
    .byteEnablesIn     (byteEnablesIn),
    .burstSizeIn       (burstSizeIn),
    .readNotWriteIn    (readNotWriteIn),
    .dataValidIn       (dataValidIn),
    .endTransactionIn  (endTransactionIn),
    .addressDataOut    (addressDataOut),
    .dataValidOut      (dataValidOut),
    .endTransactionOut (endTransactionOut),
    .busErrorOut       (busErrorOut),
    .busyOut           (busyOut)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic any_out();
    return |{addressDataOut, dataValidOut, endTransactionOut, busErrorOut, busyOut};
  endfunction

  task automatic start(input logic [31:0] addr, input logic [3:0] be, input int burst, input logic rnw);
    beginTransactionIn = 1'b1;
    addressDataIn      = addr;
    byteEnablesIn      = be;
    burstSizeIn        = 8'(burst);
    readNotWriteIn     = rnw;
    tick();
    beginTransactionIn = 1'b0;
    addressDataIn      = '0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] be, input int n);
    start(addr, be, n - 1, 1'b0);
    for (int b = 0; b < n; b++) begin
      addressDataIn    = wbuf[b];
      dataValidIn      = 1'b1;
      endTransactionIn = (b == n - 1);
      tick();
      dataValidIn      = 1'b0;
      endTransactionIn = 1'b0;
      addressDataIn    = '0;
      for (int g = 0; g < 8 && busyOut; g++) tick();
      checks++;
      if (busyOut !== 1'b0) begin
        failures++;
        $display("FAIL write_busy_timeout busy=%b required 0", busyOut);
      end
    end
  endtask

  task automatic read_burst(input logic [31:0] addr, input int burst);
    start(addr, 4'h0, burst, 1'b1);
    rd_pre_valid = dataValidOut;
    for (int b = 0; b <= burst; b++) begin
      tick();
      rd_buf[b]   = addressDataOut;
      rd_vmask[b] = dataValidOut;
    end
    tick();
    rd_end       = endTransactionOut;
    rd_end_valid = dataValidOut | (|addressDataOut);
    tick();
    rd_idle_any  = any_out();
  endtask

  task automatic check_read(input string name, input int burst, input logic [31:0] exp0,
                            input logic [31:0] exp1, input logic [31:0] exp2, input logic [31:0] exp3);
    logic [31:0] exp_w [4];
    exp_w = '{exp0, exp1, exp2, exp3};
    checks++;
    if (rd_pre_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_wait_cycle valid=%b required 0", name, rd_pre_valid);
    end
    for (int b = 0; b <= burst && b < 4; b++) begin
      checks++;
      if (rd_vmask[b] !== 1'b1 || rd_buf[b] !== exp_w[b]) begin
        failures++;
        $display("FAIL %s_beat%0d valid=%b data=%h required valid=1 data=%h", name, b, rd_vmask[b], rd_buf[b], exp_w[b]);
      end
    end
    checks++;
    if (rd_end !== 1'b1 || rd_end_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_end end=%b valid_or_data=%b required end=1 valid_or_data=0", name, rd_end, rd_end_valid);
    end
    checks++;
    if (rd_idle_any !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle outputs_nonzero=%b required 0", name, rd_idle_any);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (addressDataOut !== 32'h0 || dataValidOut !== 1'b0 || endTransactionOut !== 1'b0 ||
        busErrorOut !== 1'b0 || busyOut !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs data=%h valid=%b end=%b err=%b busy=%b required all 0",
               addressDataOut, dataValidOut, endTransactionOut, busErrorOut, busyOut);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (any_out() !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset outputs_nonzero=%b required 0", any_out());
    end
  endtask

  task automatic test_read;
    wbuf[0] = WA; wbuf[1] = WB; wbuf[2] = WC; wbuf[3] = WD;
    write_burst(BASE, 4'hF, 4);
    read_burst(BASE, 3);
    check_read("read4", 3, WA, WB, WC, WD);
  endtask

  task automatic test_byte_enables;
    wbuf[0] = 32'hAABB_CCDD;
    write_burst(BASE + 32'h8, 4'b0011, 1);
    read_burst(BASE, 3);
    check_read("byte_en", 3, WA, WB, WC_BE, WD);
  endtask

  task automatic test_wait_states;
    for (int i = 0; i < 5; i++) wbuf[i] = 32'h0;
    write_burst(BASE + 32'h40, 4'hF, 5);
    start(BASE + 32'h40, 4'hF, 3, 1'b0);
    for (int k = 0; k < 10; k++) begin
      addressDataIn = 32'hD000_0000 + 32'(k);
      dataValidIn   = 1'b1;
      checks++;
      if (busyOut !== ((k % 3) != 0)) begin
        failures++;
        $display("FAIL wait_busy_cycle%0d busy=%b required %b", k, busyOut, ((k % 3) != 0));
      end
      tick();
    end
    dataValidIn      = 1'b0;
    addressDataIn    = '0;
    endTransactionIn = 1'b1;
    checks++;
    if (busyOut !== 1'b1) begin
      failures++;
      $display("FAIL wait_busy_last busy=%b required 1", busyOut);
    end
    tick();
    endTransactionIn = 1'b0;
    checks++;
    if (any_out() !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle outputs_nonzero=%b required 0", any_out());
    end
    read_burst(BASE + 32'h40, 4);
    check_read("wait_words", 3, 32'hD000_0000, 32'hD000_0003, 32'hD000_0006, 32'hD000_0009);
    checks++;
    if (rd_buf[4] !== 32'h0) begin
      failures++;
      $display("FAIL wait_fifth_word data=%h required 00000000", rd_buf[4]);
    end
  endtask

  task automatic check_error(input string name);
    checks++;
    if (busErrorOut !== 1'b1 || endTransactionOut !== 1'b1 || dataValidOut !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse err=%b end=%b valid=%b required err=1 end=1 valid=0",
               name, busErrorOut, endTransactionOut, dataValidOut);
    end
    tick();
    checks++;
    if (any_out() !== 1'b0) begin
      failures++;
      $display("FAIL %s_after outputs_nonzero=%b required 0", name, any_out());
    end
  endtask

  task automatic test_errors;
    start(BASE + 32'h2, 4'hF, 0, 1'b0);
    check_error("err_misaligned");
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h5080_0000 + 32'(i);
    write_burst(BASE + 32'h7F0, 4'hF, 4);
    start(BASE + 32'h7F8, 4'hF, 3, 1'b0);
    addressDataIn = 32'hDEAD_BEEF;
    dataValidIn   = 1'b1;
    check_error("err_overrun_write");
    dataValidIn   = 1'b0;
    addressDataIn = '0;
    start(BASE + 32'h7F8, 4'hF, 3, 1'b1);
    check_error("err_overrun_read");
    read_burst(BASE + 32'h7F0, 3);
    check_read("err_top_words", 3, 32'h5080_0000, 32'h5080_0001, 32'h5080_0002, 32'h5080_0003);
    wbuf[0] = 32'h3000_0000; wbuf[1] = 32'h3100_0000;
    write_burst(BASE + 32'h78, 4'hF, 2);
    start(BASE + 32'h78, 4'hF, 0, 1'b0);
    addressDataIn = 32'h3A3A_3A3A;
    dataValidIn   = 1'b1;
    tick();
    dataValidIn   = 1'b0;
    tick();
    tick();
    addressDataIn = 32'h3B3B_3B3B;
    dataValidIn   = 1'b1;
    tick();
    dataValidIn   = 1'b0;
    addressDataIn = '0;
    check_error("err_extra_beat");
    read_burst(BASE + 32'h78, 1);
    check_read("extra_beat_words", 1, 32'h3A3A_3A3A, 32'h3100_0000, 32'h0, 32'h0);
  endtask

  task automatic test_unselected;
    start(BASE + 32'h800, 4'hF, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (any_out() !== 1'b0) begin
        failures++;
        $display("FAIL unsel_read_cycle%0d outputs_nonzero=%b required 0", i, any_out());
      end
      tick();
    end
    start(BASE + 32'h800, 4'hF, 0, 1'b0);
    addressDataIn    = 32'h0BAD_0BAD;
    dataValidIn      = 1'b1;
    endTransactionIn = 1'b1;
    tick();
    dataValidIn      = 1'b0;
    endTransactionIn = 1'b0;
    addressDataIn    = '0;
    checks++;
    if (any_out() !== 1'b0) begin
      failures++;
      $display("FAIL unsel_write outputs_nonzero=%b required 0", any_out());
    end
    read_burst(BASE, 0);
    check_read("unsel_word0", 0, WA, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_abort;
    start(BASE, 4'h0, 7, 1'b1);
    tick();
    checks++;
    if (dataValidOut !== 1'b1 || addressDataOut !== WA) begin
      failures++;
      $display("FAIL abort_beat0 valid=%b data=%h required valid=1 data=%h", dataValidOut, addressDataOut, WA);
    end
    endTransactionIn = 1'b1;
    tick();
    endTransactionIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (any_out() !== 1'b0) begin
        failures++;
        $display("FAIL abort_cycle%0d outputs_nonzero=%b required 0", i, any_out());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h4444_0004 + 32'(i);
    write_burst(BASE + 32'h10, 4'hF, 4);
    start(BASE, 4'h0, 7, 1'b1);
    tick();
    tick();
    tick();
    checks++;
    if (dataValidOut !== 1'b1 || addressDataOut !== WC_BE) begin
      failures++;
      $display("FAIL midreset_beat2 valid=%b data=%h required valid=1 data=%h", dataValidOut, addressDataOut, WC_BE);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (any_out() !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async outputs_nonzero=%b required 0", any_out());
    end
    tick();
    reset = 1'b0;
    tick();
    read_burst(BASE, 7);
    check_read("after_reset_lo", 3, WA, WB, WC_BE, WD);
    for (int i = 4; i < 8; i++) begin
      checks++;
      if (rd_vmask[i] !== 1'b1 || rd_buf[i] !== 32'h4444_0000 + 32'(i)) begin
        failures++;
        $display("FAIL after_reset_beat%0d valid=%b data=%h required valid=1 data=%h",
                 i, rd_vmask[i], rd_buf[i], 32'h4444_0000 + 32'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_byte_enables();
    test_wait_states();
    test_errors();
    test_unselected();
    test_abort();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
